// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP = 4;

    // Major opcodes decode keys on; kept here so both stages agree.
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of {instr, pc} with flush and occupancy count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [CNT_W-1:0]   count
);

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [INSTR_W-1:0] instr_d [DEPTH];
    logic [ADDR_W-1:0]  pc_q    [DEPTH];
    logic [ADDR_W-1:0]  pc_d    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Pointer/count next state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = push_instr;
                pc_d[wr_ptr_q]    = push_pc;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign head_instr = instr_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];
    assign count      = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC ownership, credit-limited imem requests, response drop after redirect,
// and a buffered valid/ready interface to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   q_count;
    logic [INSTR_W-1:0] q_head_instr;
    logic [ADDR_W-1:0]  q_head_pc;
    logic               q_push, q_pop, q_flush;
    logic               credit_ok, accept;
    logic [ADDR_W-1:0]  redirect_pc_aligned;
    logic               unused_redirect_lsb;

    assign redirect_pc_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Queued plus in-flight words never exceed DEPTH, so the queue cannot overflow.
    assign credit_ok      = (SUM_W'(q_count) + SUM_W'(out_q)) < SUM_W'(DEPTH);
    assign imem_req_valid = credit_ok && !redirect_valid && rst_n;
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign if_valid = (q_count != '0);
    assign if_instr = if_valid ? q_head_instr : NOP_INSTR;
    assign if_pc    = if_valid ? q_head_pc : '0;

    // Next-state for PCs, credits and drop counter; redirect has highest priority.
    always_comb begin
        out_d      = out_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
        fetch_pc_d = accept ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        q_push     = 1'b0;
        q_pop      = if_valid && if_ready;
        q_flush    = 1'b0;
        if (redirect_valid) begin
            q_flush    = 1'b1;
            q_pop      = 1'b0;
            fetch_pc_d = redirect_pc_aligned;
            rsp_pc_d   = redirect_pc_aligned;
            // Every word still owed by memory belongs to the abandoned path.
            drop_d     = out_d;
        end else if (imem_rsp_valid) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                q_push   = 1'b1;
                rsp_pc_d = rsp_pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (q_flush),
        .push       (q_push),
        .push_instr (imem_rsp_data),
        .push_pc    (rsp_pc_q),
        .pop        (q_pop),
        .head_instr (q_head_instr),
        .head_pc    (q_head_pc),
        .count      (q_count)
    );

    // A response with nothing outstanding means the memory broke ordering.
    rsp_without_req_a : assert property (
        @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (out_q != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          pops  = 0;
    int          p0;
    bit          chk_en = 1'b0;
    bit          rdy_pat_en = 1'b0;
    logic [7:0]  rdy_pat = 8'b1011_0010;
    logic [31:0] exp_pc = '0;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'h0000_0013);
        chk({tag, "_if_pc"}, if_pc, 32'h0);
    endtask

    // One clock: sample mid-cycle, advance, then update the memory model and return mid-cycle.
    task automatic cycle();
        bit acc, rspv, pop;
        logic [31:0] a;
        acc  = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        rspv = imem_rsp_valid;
        pop  = if_valid && if_ready && !redirect_valid && rst_n;
        if (chk_en && pop) begin
            chk("stream_pc", if_pc, exp_pc);
            chk("stream_instr", if_instr, word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        @(posedge clk);
        cyc++;
        #1;
        redirect_valid = 1'b0;
        if (rspv && mq_addr.size() > 0) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (acc) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat - 1);
        end
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        if (rdy_pat_en) imem_req_ready = rdy_pat[cyc % 8];
        #4;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #5;
        reset_checks("rst");

        // 1: free-running stream, 1-cycle memory
        rst_n = 1'b1;
        #1;
        chk("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        #2;
        if_ready = 1'b1;
        chk_en   = 1'b1;
        exp_pc   = 32'h0;
        cycle();
        chk("t1_no_bypass", {31'b0, if_valid}, 32'd0);
        chk("t1_second_addr", imem_req_addr, 32'h4);
        cycle();
        chk("t1_lat2_valid", {31'b0, if_valid}, 32'd1);
        chk("t1_lat2_pc", if_pc, 32'h0);
        chk("t1_lat2_instr", if_instr, word(32'h0));
        repeat (10) cycle();
        chk("t1_pops", pops, 32'd10);
        chk("t1_exp_pc", exp_pc, 32'd40);

        // 2: decode stalls, credits throttle fetch, then release
        if_ready = 1'b0;
        repeat (6) cycle();
        chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_head_valid", {31'b0, if_valid}, 32'd1);
        chk("t2_head_pc", if_pc, 32'd40);
        chk("t2_head_instr", if_instr, word(32'd40));
        if_ready = 1'b1;
        cycle();
        chk("t2_resume_req", {31'b0, imem_req_valid}, 32'd1);
        repeat (8) cycle();

        // 3: redirect with several words in flight
        lat = 3;
        repeat (8) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3_no_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
        cycle();
        exp_pc = 32'h100;
        chk("t3_new_addr", imem_req_addr, 32'h100);
        chk("t3_flushed", {31'b0, if_valid}, 32'd0);
        p0 = pops;
        repeat (12) cycle();
        chk("t3_progress", {31'b0, pops > p0}, 32'd1);

        // 4: unaligned redirect coinciding with a response
        lat = 1;
        repeat (6) cycle();
        for (int i = 0; i < 10 && !imem_rsp_valid; i++) cycle();
        chk("t4_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        cycle();
        exp_pc = 32'h200;
        chk("t4_aligned_addr", imem_req_addr, 32'h200);
        p0 = pops;
        repeat (10) cycle();
        chk("t4_progress", {31'b0, pops > p0}, 32'd1);

        // 5: toggling request ready with 3-cycle memory
        lat        = 3;
        rdy_pat_en = 1'b1;
        p0         = pops;
        repeat (40) cycle();
        chk("t5_progress", {31'b0, pops > p0 + 8}, 32'd1);
        rdy_pat_en     = 1'b0;
        imem_req_ready = 1'b1;
        repeat (8) cycle();

        // 6: reset mid-stream
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        #1;
        reset_checks("t6");
        repeat (2) cycle();
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        lat    = 1;
        #1;
        chk("t6_refetch_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t6_refetch_addr", imem_req_addr, 32'h0);
        p0 = pops;
        repeat (10) cycle();
        chk("t6_pops", pops - p0, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
